// File: rtl/alu_result_if.sv
// Handshake bundle between the ALU (master) and its registered result stage (slave).
// It also carries the head-entry status and the monitoring outputs.
interface alu_result_if #(
    parameter int DATA_W = 65,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [5:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              out_neg;
    logic              out_bool;
    logic              out_illegal;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        output in_valid, in_result, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, out_neg,
               out_bool, out_illegal, occupancy, retired_cnt
    );

    modport slave (
        input  in_valid, in_result, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, out_neg,
               out_bool, out_illegal, occupancy, retired_cnt
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: small FIFO with per-entry status flags and a retired-result counter.
// A stalled consumer backs up into the FIFO, so the ALU operand path keeps moving.
module alu_result_stage #(
    parameter int DATA_W = 65,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_result_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag;
        logic              zero;
        logic              neg;
        logic              bool_f;
        logic              illegal;
    } entry_t;

    // Flags are frozen at push time, so the head only ever exposes stored bits.
    function automatic entry_t make_entry(input logic [DATA_W-1:0] result,
                                          input logic [5:0]        op,
                                          input logic [TAG_W-1:0]  tag);
        entry_t e;
        e.result  = result;
        e.tag     = tag;
        e.zero    = (result == '0);
        e.neg     = result[DATA_W-1];
        e.illegal = op[5];
        e.bool_f  = !op[5] && (op[4:0] >= 5'h0E);
        return e;
    endfunction

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_s, out_valid_s, push_s, pop_s;
    entry_t           head_s;

    assign in_ready_s  = (occ_q < FULL_OCC);
    assign out_valid_s = (occ_q != '0);
    assign push_s      = bus.in_valid && in_ready_s;
    assign pop_s       = out_valid_s && bus.out_ready;

    // Next occupancy from the push/pop pair.
    always_comb begin
        occ_d = occ_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pointer, occupancy and counter state; rst outranks flush, and flush outranks traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                cnt_q    <= cnt_q + CNT_W'(1);
            end
            occ_q <= occ_d;
        end
    end

    // Entry storage; contents are dont-care until occupancy says otherwise.
    always_ff @(posedge clk) begin
        if (push_s && !rst && !flush) begin
            mem_q[wr_ptr_q] <= make_entry(bus.in_result, bus.in_op, bus.in_tag);
        end
    end

    // Head view is masked to zero while the FIFO is empty.
    always_comb begin
        head_s = '0;
        if (out_valid_s) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_result  = head_s.result;
    assign bus.out_tag     = head_s.tag;
    assign bus.out_zero    = head_s.zero;
    assign bus.out_neg     = head_s.neg;
    assign bus.out_bool    = head_s.bool_f;
    assign bus.out_illegal = head_s.illegal;
    assign bus.occupancy   = occ_q;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;
    localparam int DATA_W = 65;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 32;

    logic clk;
    logic rst;
    logic flush;
    int   err_cnt;
    int   chk_cnt;
    logic [31:0]       cnt_base;
    logic [DATA_W-1:0] big_r;

    alu_result_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    alu_result_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [DATA_W-1:0] res, input logic [5:0] op, input logic [TAG_W-1:0] tag);
        bus.in_valid  = 1'b1;
        bus.in_result = res;
        bus.in_op     = op;
        bus.in_tag    = tag;
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_op     = 6'h00;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset then idle
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_occ", 128'(bus.occupancy), 128'(0));
        check("rst_ready", 128'(bus.in_ready), 128'(1));
        check("rst_cnt", 128'(bus.retired_cnt), 128'(0));
        check("rst_result", 128'(bus.out_result), 128'(0));

        // Single push, held while stalled
        drive_push(65'd5, 6'h00, 4'd3);
        step();
        bus.in_valid = 1'b0;
        check("p1_valid", 128'(bus.out_valid), 128'(1));
        check("p1_zero", 128'(bus.out_zero), 128'(0));
        check("p1_bool", 128'(bus.out_bool), 128'(0));
        for (int i = 0; i < 3; i++) begin
            check("p1_result", 128'(bus.out_result), 128'(5));
            check("p1_tag", 128'(bus.out_tag), 128'(3));
            check("p1_occ", 128'(bus.occupancy), 128'(1));
            step();
        end

        // Fill to full; refused push during a pop
        drive_push(65'd7, 6'h01, 4'd4);
        step();
        check("full_occ", 128'(bus.occupancy), 128'(DEPTH));
        check("full_ready", 128'(bus.in_ready), 128'(0));
        drive_push(65'd9, 6'h02, 4'd9);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("fullpop_occ", 128'(bus.occupancy), 128'(DEPTH - 1));
        check("fullpop_tag", 128'(bus.out_tag), 128'(4));
        check("fullpop_cnt", 128'(bus.retired_cnt), 128'(1));
        step();
        bus.out_ready = 1'b0;
        check("drain_valid", 128'(bus.out_valid), 128'(0));
        check("drain_result", 128'(bus.out_result), 128'(0));
        check("drain_tag", 128'(bus.out_tag), 128'(0));
        check("drain_cnt", 128'(bus.retired_cnt), 128'(2));

        // Flag derivation
        big_r = '0;
        big_r[DATA_W-1] = 1'b1;
        drive_push(65'd0, 6'h11, 4'd1);
        step();
        drive_push(big_r, 6'h20, 4'd2);
        step();
        bus.in_valid = 1'b0;
        check("f1_zero", 128'(bus.out_zero), 128'(1));
        check("f1_bool", 128'(bus.out_bool), 128'(1));
        check("f1_neg", 128'(bus.out_neg), 128'(0));
        check("f1_illegal", 128'(bus.out_illegal), 128'(0));
        bus.out_ready = 1'b1;
        step();
        check("f2_neg", 128'(bus.out_neg), 128'(1));
        check("f2_illegal", 128'(bus.out_illegal), 128'(1));
        check("f2_bool", 128'(bus.out_bool), 128'(0));
        check("f2_zero", 128'(bus.out_zero), 128'(0));
        check("f2_result", 128'(bus.out_result), 128'(big_r));
        step();
        check("f_cnt", 128'(bus.retired_cnt), 128'(4));
        check("f_occ", 128'(bus.occupancy), 128'(0));

        // Streaming push+pop of 10 entries
        cnt_base = bus.retired_cnt;
        for (int i = 0; i < 10; i++) begin
            drive_push(DATA_W'(i + 100), 6'h03, TAG_W'(i));
            step();
            check("st_tag", 128'(bus.out_tag), 128'(i));
            check("st_occ", 128'(bus.occupancy), 128'(1));
        end
        bus.in_valid = 1'b0;
        step();
        check("st_cnt", 128'(bus.retired_cnt - cnt_base), 128'(10));
        check("st_valid", 128'(bus.out_valid), 128'(0));

        // Flush with two entries, concurrent handshake attempts
        bus.out_ready = 1'b0;
        drive_push(65'd1, 6'h00, 4'd5);
        step();
        drive_push(65'd2, 6'h00, 4'd6);
        step();
        cnt_base = bus.retired_cnt;
        drive_push(65'd3, 6'h00, 4'd7);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("fl_occ", 128'(bus.occupancy), 128'(0));
        check("fl_valid", 128'(bus.out_valid), 128'(0));
        check("fl_ready", 128'(bus.in_ready), 128'(1));
        check("fl_cnt", 128'(bus.retired_cnt), 128'(cnt_base));

        // Flush with one entry: push and pop both possible but suppressed
        drive_push(65'd8, 6'h00, 4'd8);
        step();
        drive_push(65'd9, 6'h00, 4'd9);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("fl1_occ", 128'(bus.occupancy), 128'(0));
        check("fl1_cnt", 128'(bus.retired_cnt), 128'(cnt_base));

        // rst and flush together
        drive_push(65'd10, 6'h00, 4'd10);
        step();
        drive_push(65'd11, 6'h00, 4'd11);
        step();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("rf_occ", 128'(bus.occupancy), 128'(0));
        check("rf_cnt", 128'(bus.retired_cnt), 128'(0));
        check("rf_valid", 128'(bus.out_valid), 128'(0));
        drive_push(65'd12, 6'h00, 4'd12);
        step();
        bus.in_valid = 1'b0;
        check("rf_tag", 128'(bus.out_tag), 128'(12));
        check("rf_result", 128'(bus.out_result), 128'(12));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
